camera_run_encoder: RTL and testbench

//  Sits directly downstream of the camera (real sensor or fake generator) on the pclk domain.
//  - Thresholds each pixel's luminance byte and tracks the frame's line and pixel position from href/vsync.
//  - Encodes each horizontal run of bright pixels as one entry: row, start column, end column.
//  - Entries go through an internal FIFO with a valid/ready output for the downstream blob/centroid stage.
//  - An end-of-frame marker entry follows the last run of every frame.

---
 rtl/camera_run_encoder.sv | 259 +++++++++++++++++++++++++
 tb/tb_camera_run_encoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_run_encoder.sv
// Thresholds camera luminance on the pclk domain and encodes each horizontal run of
// bright pixels as a (row, xStart, xEnd) entry, queued with an end-of-frame marker.
module camera_run_encoder #(
    parameter int unsigned PCLK_PER_PIXEL = 2,
    parameter int unsigned WIDTH          = 1280,
    parameter int unsigned HEIGHT         = 800,
    parameter int unsigned THRESHOLD      = 128,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                      pclk,
    input  logic                      reset_n,
    input  logic                      href,
    input  logic                      vsync,
    input  logic [7:0]                camData,
    input  logic                      runReady,
    output logic                      runValid,
    output logic                      runEof,
    output logic                      runOvf,
    output logic [$clog2(HEIGHT)-1:0] runY,
    output logic [$clog2(WIDTH)-1:0]  runXStart,
    output logic [$clog2(WIDTH)-1:0]  runXEnd,
    output logic [15:0]               overflowCount
);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT + 1);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = (PCLK_PER_PIXEL > 1) ? $clog2(PCLK_PER_PIXEL) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic          eof;
        logic          ovf;
        logic [YW-1:0] y;
        logic [XW-1:0] xs;
        logic [XW-1:0] xe;
    } entry_t;

    typedef enum logic {IDLE, IN_RUN} state_t;

    // Input registers; vsync idles high so resetting it high avoids a false frame start
    logic       href_q, href_d, vsync_q, vsync_d;
    logic [7:0] data_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            href_q  <= 1'b0;
            href_d  <= 1'b0;
            vsync_q <= 1'b1;
            vsync_d <= 1'b1;
            data_q  <= '0;
        end else begin
            href_q  <= href;
            href_d  <= href_q;
            vsync_q <= vsync;
            vsync_d <= vsync_q;
            data_q  <= camData;
        end
    end

    logic href_rise_c, href_fall_c, vsync_rise_c, vsync_fall_c;
    assign href_rise_c  = href_q & ~href_d;
    assign href_fall_c  = ~href_q & href_d;
    assign vsync_rise_c = vsync_q & ~vsync_d;
    assign vsync_fall_c = ~vsync_q & vsync_d;

    // Frame/line position; the href-rise byte is itself pixel 0 at phase 0
    logic          synced_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q, col_eff_c;
    logic [PW-1:0] phase_q, phase_eff_c;
    logic          pix_eval_c;

    assign phase_eff_c = href_rise_c ? '0 : phase_q;
    assign col_eff_c   = href_rise_c ? '0 : col_q;
    assign pix_eval_c  = synced_q & href_q & (phase_eff_c == '0);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            synced_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            phase_q  <= '0;
        end else begin
            if (vsync_rise_c) begin
                synced_q <= 1'b1;
                row_q    <= '0;
            end else if (synced_q && href_fall_c && (row_q < RW'(HEIGHT))) begin
                row_q <= row_q + RW'(1);
            end
            if (href_q) begin
                phase_q <= (phase_eff_c == PW'(PCLK_PER_PIXEL - 1)) ? '0 : phase_eff_c + PW'(1);
                col_q   <= (pix_eval_c && (col_eff_c < CW'(WIDTH))) ? col_eff_c + CW'(1) : col_eff_c;
            end
        end
    end

    // Pixel stage feeding the run FSM
    logic          s1_pix_q, s1_bright_q, s1_last_q, s1_line_end_q, s1_frame_end_q;
    logic [XW-1:0] s1_col_q;
    logic [YW-1:0] s1_row_q, eof_y_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pix_q       <= 1'b0;
            s1_bright_q    <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_line_end_q  <= 1'b0;
            s1_frame_end_q <= 1'b0;
            s1_col_q       <= '0;
            s1_row_q       <= '0;
            eof_y_q        <= '0;
        end else begin
            s1_pix_q       <= pix_eval_c && (row_q < RW'(HEIGHT)) && (col_eff_c < CW'(WIDTH));
            s1_bright_q    <= {1'b0, data_q} >= 9'(THRESHOLD);
            s1_last_q      <= col_eff_c == CW'(WIDTH - 1);
            s1_line_end_q  <= synced_q & href_fall_c;
            s1_frame_end_q <= synced_q & vsync_fall_c;
            s1_col_q       <= XW'(col_eff_c);
            s1_row_q       <= YW'(row_q);
            if (synced_q && vsync_fall_c) eof_y_q <= YW'(row_q);
        end
    end

    // Run FSM
    state_t        state_q, state_n;
    logic          run_load_c, run_ext_c, run_close_c;
    entry_t        close_entry_c;
    logic [YW-1:0] run_y_q;
    logic [XW-1:0] run_xs_q, run_xe_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (s1_pix_q && s1_bright_q && !s1_last_q) state_n = IDLE == IDLE ? IN_RUN : IDLE;
            IN_RUN:  if (s1_frame_end_q || s1_line_end_q ||
                         (s1_pix_q && (!s1_bright_q || s1_last_q))) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        run_load_c    = 1'b0;
        run_ext_c     = 1'b0;
        run_close_c   = 1'b0;
        close_entry_c = '0;
        case (state_q)
            IDLE: begin
                run_load_c  = s1_pix_q & s1_bright_q;
                run_close_c = s1_pix_q & s1_bright_q & s1_last_q;
            end
            IN_RUN: begin
                run_ext_c   = s1_pix_q & s1_bright_q;
                run_close_c = s1_frame_end_q | s1_line_end_q |
                              (s1_pix_q & (~s1_bright_q | s1_last_q));
            end
            default: ;
        endcase
        close_entry_c.y  = (state_q == IDLE) ? s1_row_q : run_y_q;
        close_entry_c.xs = (state_q == IDLE) ? s1_col_q : run_xs_q;
        close_entry_c.xe = (s1_pix_q && s1_bright_q) ? s1_col_q : run_xe_q;
    end

    // Push requests; the EOF request trails the frame-end run close by one cycle
    logic   req_run_q, eof_pend_q, req_eof_q;
    entry_t req_entry_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            run_y_q     <= '0;
            run_xs_q    <= '0;
            run_xe_q    <= '0;
            req_run_q   <= 1'b0;
            eof_pend_q  <= 1'b0;
            req_eof_q   <= 1'b0;
            req_entry_q <= '0;
        end else begin
            if (run_load_c) begin
                run_y_q  <= s1_row_q;
                run_xs_q <= s1_col_q;
                run_xe_q <= s1_col_q;
            end else if (run_ext_c) begin
                run_xe_q <= s1_col_q;
            end
            req_run_q   <= run_close_c;
            req_entry_q <= close_entry_c;
            eof_pend_q  <= s1_frame_end_q;
            req_eof_q   <= eof_pend_q;
        end
    end

    // FWFT FIFO with registered head; runs leave one slot free for EOF
    entry_t        mem [FIFO_DEPTH];
    entry_t        head_q, wdata_c, head_n_c;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_n_c;
    logic [OW-1:0] count_q, count_n_c;
    logic          valid_q, frame_ovf_q, push_c, pop_c, run_drop_c, eof_drop_c;
    logic [15:0]   ovf_cnt_q;
    logic [16:0]   ovf_sum_c;

    always_comb begin
        wdata_c = req_entry_q;
        if (req_eof_q) begin
            wdata_c     = '0;
            wdata_c.eof = 1'b1;
            wdata_c.ovf = frame_ovf_q;
            wdata_c.y   = eof_y_q;
        end
        push_c     = req_eof_q ? (count_q < OW'(FIFO_DEPTH))
                               : (req_run_q && (count_q < OW'(FIFO_DEPTH - 1)));
        run_drop_c = req_run_q && (req_eof_q || (count_q >= OW'(FIFO_DEPTH - 1)));
        eof_drop_c = req_eof_q && (count_q >= OW'(FIFO_DEPTH));
        pop_c      = valid_q & runReady;
        rd_ptr_n_c = rd_ptr_q + AW'(pop_c);
        count_n_c  = count_q + OW'(push_c) - OW'(pop_c);
        head_n_c   = (push_c && (wr_ptr_q == rd_ptr_n_c)) ? wdata_c : mem[rd_ptr_n_c];
        ovf_sum_c  = {1'b0, ovf_cnt_q} + 17'(run_drop_c) + 17'(eof_drop_c);
    end

    always_ff @(posedge pclk) begin
        if (push_c) mem[wr_ptr_q] <= wdata_c;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            head_q      <= '0;
            ovf_cnt_q   <= '0;
            frame_ovf_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q  <= rd_ptr_n_c;
            count_q   <= count_n_c;
            valid_q   <= count_n_c != '0;
            head_q    <= head_n_c;
            ovf_cnt_q <= ovf_sum_c[16] ? 16'hFFFF : ovf_sum_c[15:0];
            if (run_drop_c)        frame_ovf_q <= 1'b1;
            else if (vsync_rise_c) frame_ovf_q <= 1'b0;
        end
    end

    assign runValid      = valid_q;
    assign runEof        = head_q.eof;
    assign runOvf        = head_q.ovf;
    assign runY          = head_q.y;
    assign runXStart     = head_q.xs;
    assign runXEnd       = head_q.xe;
    assign overflowCount = ovf_cnt_q;

endmodule

// File: tb/tb_camera_run_encoder.sv
// Directed bench for camera_run_encoder: expected entries are queued as stimulus is
// issued and a monitor pops and compares them whenever the DUT hands one out.
module tb_camera_run_encoder;
    logic        pclk = 1'b0;
    logic        reset_n, href, vsync, runReady;
    logic [7:0]  camData;
    logic        runValid, runEof, runOvf;
    logic [9:0]  runY;
    logic [10:0] runXStart, runXEnd;
    logic [15:0] overflowCount;

    camera_run_encoder dut (
        .pclk(pclk), .reset_n(reset_n), .href(href), .vsync(vsync), .camData(camData),
        .runReady(runReady), .runValid(runValid), .runEof(runEof), .runOvf(runOvf),
        .runY(runY), .runXStart(runXStart), .runXEnd(runXEnd), .overflowCount(overflowCount)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic        eof;
        logic        ovf;
        logic [9:0]  y;
        logic [10:0] xs;
        logic [10:0] xe;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         first_valid_cyc = -1;
    int         watch_pix = -1;
    int         watch_cyc = 0;
    logic [7:0] lum [0:1299];

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (runValid && first_valid_cyc < 0) first_valid_cyc <= cyc;
    end

    function automatic exp_t mk(input logic eof, input logic ovf, input int y, input int xs, input int xe);
        exp_t e;
        e.eof = eof;
        e.ovf = ovf;
        e.y   = 10'(y);
        e.xs  = 11'(xs);
        e.xe  = 11'(xe);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted head entry is compared with the oldest expectation
    always @(negedge pclk) begin
        exp_t e;
        exp_t a;
        if (reset_n && runValid && runReady) begin
            a = {runEof, runOvf, runY, runXStart, runXEnd};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_entry: got eof=%0d ovf=%0d y=%0d xs=%0d xe=%0d, required none",
                         a.eof, a.ovf, a.y, a.xs, a.xe);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL entry: got eof=%0d ovf=%0d y=%0d xs=%0d xe=%0d, required eof=%0d ovf=%0d y=%0d xs=%0d xe=%0d",
                             a.eof, a.ovf, a.y, a.xs, a.xe, e.eof, e.ovf, e.y, e.xs, e.xe);
                end
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_lum();
        for (int i = 0; i < 1300; i++) lum[i] = 8'h00;
    endtask

    task automatic drive_pixel(input int p);
        for (int ph = 0; ph < 2; ph++) begin
            href    = 1'b1;
            camData = (ph == 0) ? lum[p] : ~lum[p];
            if (ph == 0 && p == watch_pix) watch_cyc = cyc;
            tick();
        end
    endtask

    task automatic send_line(input int npix);
        for (int p = 0; p < npix; p++) drive_pixel(p);
        href    = 1'b0;
        camData = 8'h00;
        repeat (10) tick();
    endtask

    // Low pulse of 8 cycles; optionally accept exactly one entry on the EOF write cycle
    task automatic vsync_pulse(input bit ready_pulse);
        vsync = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ready_pulse && i == 4) runReady = 1'b1;
            if (ready_pulse && i == 5) runReady = 1'b0;
        end
        vsync = 1'b1;
        repeat (10) tick();
    endtask

    task automatic drain();
        int t;
        t = 0;
        runReady = 1'b1;
        while (exp_q.size() != 0 && t < 2000) begin
            tick();
            t++;
        end
        repeat (5) tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d entries still pending, required 0", exp_q.size());
        end
        check("empty_after_drain", 32'(runValid), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        href     = 1'b0;
        vsync    = 1'b1;
        camData  = 8'h00;
        runReady = 1'b1;
        repeat (3) tick();
        check("reset_valid", 32'(runValid), 32'd0);
        check("reset_ovf_count", 32'(overflowCount), 32'd0);
        check("reset_head", 32'({runEof, runOvf, runY, runXStart, runXEnd}), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Before the first vsync rise everything is discarded
        clear_lum();
        for (int i = 0; i < 10; i++) lum[i] = 8'hFF;
        send_line(10);
        vsync_pulse(1'b0);

        // Frame A, line 0: pixels 10..13 bright
        clear_lum();
        for (int i = 10; i <= 13; i++) lum[i] = 8'hFF;
        exp_q.push_back(mk(0, 0, 0, 10, 13));
        watch_pix = 14;
        send_line(20);
        watch_pix = -1;
        check("latency_k_plus_3", 32'(first_valid_cyc), 32'(watch_cyc + 1 + 3));

        // Line 1: 127/128 alternating -> odd columns are single-pixel runs
        clear_lum();
        for (int p = 0; p < 64; p++) begin
            lum[p] = (p % 2 == 1) ? 8'd128 : 8'd127;
            if (p % 2 == 1) exp_q.push_back(mk(0, 0, 1, p, p));
        end
        send_line(64);

        // Line 2: 8'h7F only -> no entries
        for (int p = 0; p < 100; p++) lum[p] = 8'h7F;
        send_line(100);

        // Line 3: run up to the last column, extra pixels past WIDTH ignored
        clear_lum();
        for (int p = 1276; p < 1290; p++) lum[p] = 8'hFF;
        exp_q.push_back(mk(0, 0, 3, 1276, 1279));
        send_line(1290);

        // Line 4: run from column 0 closed by href fall
        clear_lum();
        for (int p = 0; p < 5; p++) lum[p] = 8'hFF;
        exp_q.push_back(mk(0, 0, 4, 0, 4));
        send_line(5);
        exp_q.push_back(mk(1, 0, 5, 0, 0));
        vsync_pulse(1'b0);
        drain();
        check("ovf_count_frame_a", 32'(overflowCount), 32'd0);

        // Frame B: consumer stalled, 20 runs -> 15 kept, 5 dropped, EOF flags overflow
        runReady = 1'b0;
        clear_lum();
        for (int i = 0; i < 20; i++) lum[2*i] = 8'hFF;
        for (int i = 0; i < 15; i++) exp_q.push_back(mk(0, 0, 0, 2*i, 2*i));
        send_line(40);
        exp_q.push_back(mk(1, 1, 1, 0, 0));
        vsync_pulse(1'b0);
        check("ovf_count_frame_b", 32'(overflowCount), 32'd5);
        check("valid_while_stalled", 32'(runValid), 32'd1);
        drain();

        // Frame C: 15 runs queued, EOF written in the same cycle as one pop
        runReady = 1'b0;
        clear_lum();
        for (int i = 0; i < 15; i++) begin
            lum[2*i] = 8'hFF;
            exp_q.push_back(mk(0, 0, 0, 2*i, 2*i));
        end
        send_line(30);
        exp_q.push_back(mk(1, 0, 1, 0, 0));
        vsync_pulse(1'b1);
        check("ovf_count_frame_c", 32'(overflowCount), 32'd5);
        check("pending_after_pop", 32'(exp_q.size()), 32'd15);
        drain();

        // Frame D: reset in the middle of an open run
        clear_lum();
        for (int p = 5; p <= 20; p++) lum[p] = 8'hFF;
        for (int p = 0; p < 12; p++) drive_pixel(p);
        reset_n = 1'b0;
        repeat (2) tick();
        check("midrun_reset_valid", 32'(runValid), 32'd0);
        check("midrun_reset_ovf_count", 32'(overflowCount), 32'd0);
        reset_n = 1'b1;
        for (int p = 12; p < 40; p++) drive_pixel(p);
        href = 1'b0;
        repeat (10) tick();
        send_line(30);
        vsync_pulse(1'b0);
        check("unsynced_no_entries", 32'(exp_q.size()), 32'd0);

        // Frame E encodes normally after resync
        clear_lum();
        for (int p = 7; p <= 9; p++) lum[p] = 8'hFF;
        exp_q.push_back(mk(0, 0, 0, 7, 9));
        send_line(12);
        exp_q.push_back(mk(1, 0, 1, 0, 0));
        vsync_pulse(1'b0);
        drain();
        check("ovf_count_final", 32'(overflowCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
